// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle sequencer and the datapath.
// master = sequencer, slave = datapath side.
interface multicycle_control_if;
  logic [5:0] opcode_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic       i_or_d_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       reg_dst_o;
  logic       mem_to_reg_o;
  logic       reg_write_o;
  logic       alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o;
  logic [1:0] pc_source_o;
  logic       illegal_o;
  logic [3:0] state_o;

  modport master (
    input  opcode_i, zero_i, mem_ready_i,
    output pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o, reg_dst_o,
           mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o,
           illegal_o, state_o
  );

  modport slave (
    output opcode_i, zero_i, mem_ready_i,
    input  pc_write_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o, reg_dst_o,
           mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o,
           illegal_o, state_o
  );
endinterface

// File: rtl/multicycle_control.sv
// Main sequencing FSM for the multicycle MIPS datapath: fetch, decode, execute,
// memory and write-back, stalling on the memory ready handshake.
module multicycle_control (
  input logic             clk,
  input logic             reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StIExec    = 4'd8,
    StIWb      = 4'd9,
    StBranch   = 4'd10,
    StJump     = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e     state_q, state_d;
  logic [5:0] opcode_q;
  logic       pc_write, ir_write, reg_write, mem_write, mem_read, illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StFetch;
      opcode_q <= '0;
    end else begin
      state_q <= state_d;
      // Later states decode the latched opcode, not the live IR field.
      if (state_q == StDecode) opcode_q <= bus.opcode_i;
    end
  end

  always_comb begin
    state_d          = state_q;
    pc_write         = 1'b0;
    ir_write         = 1'b0;
    reg_write        = 1'b0;
    mem_write        = 1'b0;
    mem_read         = 1'b0;
    illegal          = 1'b0;
    bus.i_or_d_o     = 1'b0;
    bus.reg_dst_o    = 1'b0;
    bus.mem_to_reg_o = 1'b0;
    bus.alu_src_a_o  = 1'b0;
    bus.alu_src_b_o  = 2'b00;
    bus.alu_op_o     = 3'b000;
    bus.pc_source_o  = 2'b00;
    case (state_q)
      StFetch: begin
        mem_read        = 1'b1;
        bus.alu_src_b_o = 2'b01;
        bus.alu_op_o    = 3'b100;
        ir_write        = bus.mem_ready_i;
        pc_write        = bus.mem_ready_i;
        if (bus.mem_ready_i) state_d = StDecode;
      end
      StDecode: begin
        bus.alu_src_b_o = 2'b11;
        bus.alu_op_o    = 3'b100;
        case (bus.opcode_i)
          OpRtype:                      state_d = StRExec;
          OpLw, OpSw:                   state_d = StMemAddr;
          OpAddi, OpOri, OpAndi, OpLui: state_d = StIExec;
          OpBeq, OpBne:                 state_d = StBranch;
          OpJ:                          state_d = StJump;
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAddr: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = 2'b10;
        bus.alu_op_o    = 3'b100;
        state_d         = (opcode_q == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        mem_read     = 1'b1;
        bus.i_or_d_o = 1'b1;
        if (bus.mem_ready_i) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write        = 1'b1;
        bus.mem_to_reg_o = 1'b1;
        state_d          = StFetch;
      end
      StMemWrite: begin
        mem_write    = 1'b1;
        bus.i_or_d_o = 1'b1;
        if (bus.mem_ready_i) state_d = StFetch;
      end
      StRExec: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_op_o    = 3'b111;
        state_d         = StRWb;
      end
      StRWb: begin
        reg_write     = 1'b1;
        bus.reg_dst_o = 1'b1;
        state_d       = StFetch;
      end
      StIExec: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_src_b_o = 2'b10;
        case (opcode_q)
          OpOri:   bus.alu_op_o = 3'b010;
          OpAndi:  bus.alu_op_o = 3'b011;
          OpLui:   bus.alu_op_o = 3'b001;
          default: bus.alu_op_o = 3'b100;
        endcase
        state_d = StIWb;
      end
      StIWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        bus.alu_src_a_o = 1'b1;
        bus.alu_op_o    = 3'b101;
        bus.pc_source_o = 2'b01;
        pc_write        = (opcode_q == OpBne) ? ~bus.zero_i : bus.zero_i;
        state_d         = StFetch;
      end
      StJump: begin
        bus.pc_source_o = 2'b10;
        pc_write        = 1'b1;
        state_d         = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Reset masks every write/request strobe so an aborted access has no side effect.
  assign bus.pc_write_o  = pc_write & ~reset;
  assign bus.ir_write_o  = ir_write & ~reset;
  assign bus.reg_write_o = reg_write & ~reset;
  assign bus.mem_write_o = mem_write & ~reset;
  assign bus.mem_read_o  = mem_read & ~reset;
  assign bus.illegal_o   = illegal & ~reset;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: an instruction-level model expands each opcode into its
// expected per-cycle output trace, which is replayed against the sequencer.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } exp_t;

  typedef struct {
    logic       ready;
    logic       zero;
    logic [5:0] opc;
    exp_t       e;
  } step_t;

  step_t q[$];
  int checks   = 0;
  int failures = 0;
  logic [5:0] legal_ops [10] = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h0d, 6'h0c, 6'h0f,
                                 6'h04, 6'h05, 6'h02};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t observe();
    exp_t a;
    a.st         = bus.state_o;
    a.pc_write   = bus.pc_write_o;
    a.i_or_d     = bus.i_or_d_o;
    a.mem_read   = bus.mem_read_o;
    a.mem_write  = bus.mem_write_o;
    a.ir_write   = bus.ir_write_o;
    a.reg_dst    = bus.reg_dst_o;
    a.mem_to_reg = bus.mem_to_reg_o;
    a.reg_write  = bus.reg_write_o;
    a.alu_src_a  = bus.alu_src_a_o;
    a.alu_src_b  = bus.alu_src_b_o;
    a.alu_op     = bus.alu_op_o;
    a.pc_source  = bus.pc_source_o;
    a.illegal    = bus.illegal_o;
    return a;
  endfunction

  function automatic exp_t base(input logic [3:0] st);
    exp_t e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic push(input exp_t e, input logic ready, input logic zero, input logic [5:0] opc);
    step_t s;
    s.e = e; s.ready = ready; s.zero = zero; s.opc = opc;
    q.push_back(s);
  endtask

  // Expected trace of one instruction from its opcode, stall counts and zero flag.
  task automatic build(input logic [5:0] op, input int fstall, input int mstall, input logic z);
    exp_t e;
    logic legal;
    legal = 1'b0;
    foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;
    q.delete();
    for (int i = 0; i <= fstall; i++) begin
      e = base(4'd0);
      e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 3'b100;
      e.ir_write = (i == fstall); e.pc_write = (i == fstall);
      push(e, i == fstall, rbit(), op);
    end
    e = base(4'd1);
    e.alu_src_b = 2'b11; e.alu_op = 3'b100; e.illegal = ~legal;
    push(e, rbit(), rbit(), op);
    if (op == 6'h00) begin
      e = base(4'd6); e.alu_src_a = 1'b1; e.alu_op = 3'b111;
      push(e, rbit(), rbit(), 6'($urandom));
      e = base(4'd7); e.reg_write = 1'b1; e.reg_dst = 1'b1;
      push(e, rbit(), rbit(), 6'($urandom));
    end else if (op == 6'h23 || op == 6'h2b) begin
      e = base(4'd2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 3'b100;
      push(e, rbit(), rbit(), 6'($urandom));
      for (int i = 0; i <= mstall; i++) begin
        e = base(op == 6'h23 ? 4'd3 : 4'd5);
        e.i_or_d = 1'b1;
        if (op == 6'h23) e.mem_read = 1'b1; else e.mem_write = 1'b1;
        push(e, i == mstall, rbit(), 6'($urandom));
      end
      if (op == 6'h23) begin
        e = base(4'd4); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
        push(e, rbit(), rbit(), 6'($urandom));
      end
    end else if (op == 6'h08 || op == 6'h0d || op == 6'h0c || op == 6'h0f) begin
      e = base(4'd8); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
      e.alu_op = (op == 6'h08) ? 3'b100 : (op == 6'h0d) ? 3'b010 :
                 (op == 6'h0c) ? 3'b011 : 3'b001;
      push(e, rbit(), rbit(), 6'($urandom));
      e = base(4'd9); e.reg_write = 1'b1;
      push(e, rbit(), rbit(), 6'($urandom));
    end else if (op == 6'h04 || op == 6'h05) begin
      e = base(4'd10); e.alu_src_a = 1'b1; e.alu_op = 3'b101; e.pc_source = 2'b01;
      e.pc_write = (op == 6'h04) ? z : ~z;
      push(e, rbit(), z, 6'($urandom));
    end else if (op == 6'h02) begin
      e = base(4'd11); e.pc_source = 2'b10; e.pc_write = 1'b1;
      push(e, rbit(), rbit(), 6'($urandom));
    end
  endtask

  task automatic run(input string name, input int n);
    int lim;
    lim = (n < 0 || n > q.size()) ? q.size() : n;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      bus.mem_ready_i = q[i].ready;
      bus.zero_i      = q[i].zero;
      bus.opcode_i    = q[i].opc;
      #1;
      check_eq($sformatf("%s.state[%0d]", name, i), 32'(bus.state_o), 32'(q[i].e.st));
      check_eq($sformatf("%s.outs[%0d]", name, i), 32'(observe()), 32'(q[i].e));
    end
  endtask

  task automatic instr(input string name, input logic [5:0] op, input int fs, input int ms,
                       input logic z);
    build(op, fs, ms, z);
    run(name, -1);
  endtask

  exp_t rst_e;
  logic [5:0] rop;

  initial begin
    rst_e = base(4'd0);
    rst_e.alu_src_b = 2'b01;
    rst_e.alu_op    = 3'b100;

    reset = 1'b1;
    bus.mem_ready_i = 1'b1;
    bus.zero_i = 1'b1;
    bus.opcode_i = 6'h00;
    repeat (2) @(negedge clk);
    #1;
    check_eq("reset.outs", 32'(observe()), 32'(rst_e));
    bus.mem_ready_i = 1'b0;
    reset = 1'b0;

    instr("rtype", 6'h00, 0, 0, 1'b0);
    instr("addi", 6'h08, 0, 0, 1'b0);
    instr("lw_stall", 6'h23, 0, 3, 1'b0);
    instr("sw_stall", 6'h2b, 1, 2, 1'b0);
    instr("beq_z1", 6'h04, 0, 0, 1'b1);
    instr("beq_z0", 6'h04, 0, 0, 1'b0);
    instr("bne_z1", 6'h05, 0, 0, 1'b1);
    instr("bne_z0", 6'h05, 0, 0, 1'b0);
    instr("jump", 6'h02, 0, 0, 1'b0);
    instr("illegal", 6'h3f, 0, 0, 1'b0);
    instr("lui", 6'h0f, 0, 0, 1'b0);
    instr("ori", 6'h0d, 0, 0, 1'b0);
    instr("andi", 6'h0c, 0, 0, 1'b0);

    // Abort an LW while it is stalled in MEM_READ.
    build(6'h23, 0, 5, 1'b0);
    run("lw_abort", 5);
    #2;
    reset = 1'b1;
    #1;
    check_eq("abort.outs", 32'(observe()), 32'(rst_e));
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    reset = 1'b0;
    instr("after_abort", 6'h00, 0, 0, 1'b0);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 4) == 0) rop = 6'($urandom);
      else rop = legal_ops[$urandom_range(0, 9)];
      instr($sformatf("rnd%0d_op%02h", k, rop), rop, $urandom_range(0, 2),
            $urandom_range(0, 3), rbit());
    end

    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1;
    check_eq("final.state", 32'(bus.state_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main sequencing FSM for the multicycle MIPS datapath. It steps each instruction through fetch, decode, execute, memory and write-back. On every cycle it drives the datapath mux selects and write strobes, plus the 3-bit `alu_op_o` consumed by the ALU control decoder. It sits between the instruction register's opcode field and the shared ALU, register file, PC and unified memory, and it stalls on a memory ready handshake.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode_i  in  6  instruction bits [31:26] from the instruction register.
- zero_i  in  1  ALU zero flag, valid in BRANCH.
- mem_ready_i  in  1  memory completes the current access this cycle.
- pc_write_o  out  1  PC load strobe.
- i_or_d_o  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read_o  out  1  memory read request.
- mem_write_o  out  1  memory write request.
- ir_write_o  out  1  instruction register load.
- reg_dst_o  out  1  write register select: 0 = rt, 1 = rd.
- mem_to_reg_o  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- reg_write_o  out  1  register file write strobe.
- alu_src_a_o  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b_o  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2.
- alu_op_o  out  3  ALU operation class: 100 add, 111 R-type (function field), 001 LUI, 010 OR, 011 AND, 101 subtract/compare.
- pc_source_o  out  2  PC next select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal_o  out  1  one-cycle pulse for an unsupported opcode.
- state_o  out  4  current state encoding, for debug.

## Operation
- Moore FSM. Outputs decode from the state register only, except `pc_write_o` in BRANCH and the `mem_ready_i` qualification of strobes. Any output not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, I_EXEC=8, I_WB=9, BRANCH=10, JUMP=11. Codes 12–15 are unreachable and recover to FETCH.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=100, pc_source=00.
  - ir_write and pc_write equal `mem_ready_i`.
  - Advances to DECODE only when `mem_ready_i`=1, otherwise holds.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=100 (branch target precompute). Next state by opcode:
  - 000000 → R_EXEC
  - 100011 (LW) and 101011 (SW) → MEM_ADDR
  - 001000 (ADDI), 001101 (ORI), 001100 (ANDI), 001111 (LUI) → I_EXEC
  - 000100 (BEQ) and 000101 (BNE) → BRANCH
  - 000010 (J) → JUMP
  - Anything else → FETCH, with illegal_o=1 for this DECODE cycle.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=100. Goes to MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: mem_read=1, i_or_d=1. Holds until `mem_ready_i`, then → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until `mem_ready_i`, then → FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=111 → R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. alu_op is 100 for ADDI, 010 for ORI, 011 for ANDI, 001 for LUI. → I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=101, pc_source=01.
  - pc_write = zero_i for BEQ, !zero_i for BNE.
  - → FETCH.
- JUMP: pc_source=10, pc_write=1 → FETCH.
- Opcode latch: the opcode is captured into an internal register in DECODE. Opcode-dependent states use the latched value, so later changes on `opcode_i` have no effect.

## Timing
- Reset:
  - state=FETCH and the opcode latch is cleared to 0.
  - While reset is high, pc_write, ir_write, reg_write, mem_write, mem_read and illegal are forced to 0. Other outputs show FETCH values.
  - Asserting reset in any state, including mid-stall, aborts the instruction immediately with no write strobe.
- Latency with `mem_ready_i` held at 1:

  | Instruction | Cycles |
  |---|---|
  | R-type | 4 |
  | I-type | 4 |
  | LW | 5 |
  | SW | 4 |
  | BEQ / BNE | 3 |
  | J | 3 |
  | Illegal | 2 |

- Each cycle `mem_ready_i` is low in FETCH, MEM_READ or MEM_WRITE adds one cycle. Strobes stay low during the stall except mem_read/mem_write, which stay asserted.
- Exactly one reg_write cycle per register-writing instruction. Exactly one pc_write cycle in FETCH. At most one further pc_write cycle, in BRANCH or JUMP.

## Test plan
- Reset mid-stall: reset during MEM_READ with `mem_ready_i`=0 → state_o=0 and all strobes 0 the same cycle. After release, FETCH resumes.
- R-type then ADDI, ready held at 1 → state_o sequence 0,1,6,7,0,1,8,9. alu_op reads 111 in R_EXEC and 100 in I_EXEC; reg_dst is 1 then 0 in the write-back states.
- LW with `mem_ready_i` low for 3 cycles in MEM_READ → 8 cycles total, reg_write=1 only in MEM_WB with mem_to_reg=1. SW → mem_write held 1 until ready, no reg_write.
- BEQ with zero_i=1 → pc_write=1 in BRANCH, pc_source=01. BEQ with zero_i=0 → pc_write=0. BNE gives the inverse. All take 3 cycles.
- J → JUMP with pc_write=1 and pc_source=10. Opcode 111111 → illegal_o pulse in DECODE, back to FETCH, no reg/mem/pc writes.
- LUI, ORI, ANDI → alu_op in I_EXEC is 001, 010, 011 respectively. Changing `opcode_i` after DECODE leaves the sequence unchanged.
